keycode_event_queue: RTL and testbench

- Parametrised successor to the single 8-bit keycode export path of the video system.
- Samples an N_KEYS-slot keycode report, as written by the NIOS USB keyboard driver into a PIO, and diffs it against the previous report.
- Emits ordered press/release events into an internal FIFO.
- Game/sprite logic pops events with a valid/ready handshake instead of polling raw keycodes, so no press or release is lost between frames.

---
 rtl/kq_pkg.sv | 28 ++
 rtl/kq_fifo.sv | 66 ++++++
 rtl/keycode_event_queue.sv | 157 +++++++++++++++
 tb/tb_keycode_event_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/kq_pkg.sv
// Shared types and helpers for the keycode event queue: event polarity codes,
// scan FSM states and a slot extractor for packed keycode reports.
package kq_pkg;

    localparam logic KQ_PRESS = 1'b1;
    localparam logic KQ_REL   = 1'b0;

    // Upper bounds for the generic slot extractor; callers zero-extend into these.
    localparam int KQ_MAX_RPT_W = 512;
    localparam int KQ_MAX_KEY_W = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_REL   = 2'd1,
        SCAN_PRESS = 2'd2
    } kq_state_e;

    function automatic logic [KQ_MAX_KEY_W-1:0] kq_slot(
        input logic [KQ_MAX_RPT_W-1:0] rpt,
        input int unsigned             idx,
        input int unsigned             key_w
    );
        logic [KQ_MAX_RPT_W-1:0] shifted;
        shifted = rpt >> (idx * key_w);
        return shifted[KQ_MAX_KEY_W-1:0];
    endfunction

endpackage

// File: rtl/kq_fifo.sv
// Synchronous show-ahead FIFO: data_o presents the head entry whenever not empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module kq_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/keycode_event_queue.sv
// Diffs successive keycode reports and queues ordered release/press events
// for a valid/ready consumer, so no key transition is lost between frames.
module keycode_event_queue
    import kq_pkg::*;
#(
    parameter int N_KEYS = 6,
    parameter int KEY_W  = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk_0,
    input  logic                      reset_n,
    input  logic [N_KEYS*KEY_W-1:0]   keycode_in,
    input  logic                      flush,
    output logic                      event_valid,
    output logic [KEY_W:0]            event_data,
    input  logic                      event_ready,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      scan_busy,
    output logic                      keys_held
);

    localparam int RPT_W = N_KEYS * KEY_W;
    localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

    typedef logic [KEY_W-1:0] key_t;

    logic [RPT_W-1:0] in_q;
    logic [RPT_W-1:0] prev_q;
    logic [RPT_W-1:0] cur_q;
    logic [IDX_W-1:0] idx_q;
    kq_state_e        state_q;

    key_t       prev_slot [N_KEYS];
    key_t       cur_slot  [N_KEYS];
    key_t       scan_code;
    key_t       own_code;
    key_t       other_code;
    logic       in_other;
    logic       dup_lower;
    logic       need_push;
    logic       can_push;
    logic       stall;
    logic       push;
    logic       pop;
    logic       last_slot;
    logic       fifo_full;
    logic       fifo_empty;
    logic [KEY_W:0] push_data;

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            prev_slot[i] = key_t'(kq_slot(KQ_MAX_RPT_W'(prev_q), i, KEY_W));
            cur_slot[i]  = key_t'(kq_slot(KQ_MAX_RPT_W'(cur_q), i, KEY_W));
        end
    end

    // The scanned snapshot is prev during SCAN_REL and cur during SCAN_PRESS;
    // the membership test always looks into the other snapshot.
    always_comb begin
        scan_code  = '0;
        own_code   = '0;
        other_code = '0;
        in_other   = 1'b0;
        dup_lower  = 1'b0;
        for (int j = 0; j < N_KEYS; j++) begin
            if (IDX_W'(j) == idx_q)
                scan_code = (state_q == SCAN_PRESS) ? cur_slot[j] : prev_slot[j];
        end
        for (int j = 0; j < N_KEYS; j++) begin
            own_code   = (state_q == SCAN_PRESS) ? cur_slot[j]  : prev_slot[j];
            other_code = (state_q == SCAN_PRESS) ? prev_slot[j] : cur_slot[j];
            if (other_code == scan_code) in_other = 1'b1;
            if ((IDX_W'(j) < idx_q) && (own_code == scan_code)) dup_lower = 1'b1;
        end
        need_push = (state_q != IDLE) && (scan_code != '0) && !in_other && !dup_lower;
    end

    assign pop       = event_valid && event_ready && !flush;
    assign can_push  = !fifo_full || pop;
    assign stall     = need_push && !can_push;
    assign push      = need_push && can_push && !flush;
    assign push_data = {((state_q == SCAN_PRESS) ? KQ_PRESS : KQ_REL), scan_code};
    assign last_slot = (idx_q == IDX_W'(N_KEYS - 1));

    assign event_valid = !fifo_empty;
    assign scan_busy   = (state_q != IDLE);
    assign keys_held   = |prev_q;

    always_ff @(posedge clk_0 or negedge reset_n) begin
        if (!reset_n) begin
            in_q    <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            state_q <= IDLE;
        end else begin
            in_q <= keycode_in;
            if (flush) begin
                prev_q  <= '0;
                idx_q   <= '0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_q != prev_q) begin
                            cur_q   <= in_q;
                            idx_q   <= '0;
                            state_q <= SCAN_REL;
                        end
                    end
                    SCAN_REL: begin
                        if (!stall) begin
                            if (last_slot) begin
                                idx_q   <= '0;
                                state_q <= SCAN_PRESS;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                    SCAN_PRESS: begin
                        if (!stall) begin
                            if (last_slot) begin
                                prev_q  <= cur_q;
                                idx_q   <= '0;
                                state_q <= IDLE;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    kq_fifo #(
        .WIDTH (KEY_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_0),
        .rst_ni  (reset_n),
        .clr_i   (flush),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (event_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue (N_KEYS=6, KEY_W=8, DEPTH=4).
module tb_keycode_event_queue;

    localparam int N_KEYS = 6;
    localparam int KEY_W  = 8;
    localparam int DEPTH  = 4;

    logic                     clk_0;
    logic                     reset_n;
    logic [N_KEYS*KEY_W-1:0]  keycode_in;
    logic                     flush;
    logic                     event_valid;
    logic [KEY_W:0]           event_data;
    logic                     event_ready;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     scan_busy;
    logic                     keys_held;

    int n_pass   = 0;
    int n_checks = 0;

    keycode_event_queue #(
        .N_KEYS (N_KEYS),
        .KEY_W  (KEY_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_0       (clk_0),
        .reset_n     (reset_n),
        .keycode_in  (keycode_in),
        .flush       (flush),
        .event_valid (event_valid),
        .event_data  (event_data),
        .event_ready (event_ready),
        .fifo_count  (fifo_count),
        .scan_busy   (scan_busy),
        .keys_held   (keys_held)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic settle(input string tag);
        repeat (3) tick();
        for (int i = 0; i < 200 && scan_busy; i++) tick();
        check(tag, 32'(scan_busy), 32'd0);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 100 && !event_valid; i++) tick();
        check({tag, "_valid"}, 32'(event_valid), 32'd1);
        check(tag, 32'(event_data), exp);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [N_KEYS*KEY_W-1:0] rpt;

        reset_n     = 1'b0;
        keycode_in  = '0;
        flush       = 1'b0;
        event_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_data",  32'(event_data),  32'd0);
        check("rst_count", 32'(fifo_count),  32'd0);
        check("rst_busy",  32'(scan_busy),   32'd0);
        check("rst_held",  32'(keys_held),   32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single press: latency from report change to event_valid.
        keycode_in = 48'h0000_0000_0004;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            if (event_valid) break;
        end
        check("lat_cycles", 32'(lat), 32'd9);
        check("lat_data",   32'(event_data), 32'h104);
        check("lat_count",  32'(fifo_count), 32'd1);
        check("lat_busy",   32'(scan_busy),  32'd1);
        settle("settle1");
        check("held_after_press", 32'(keys_held), 32'd1);
        pop_expect("pop_104", 32'h104);
        check("count_after_pop", 32'(fifo_count), 32'd0);

        // {04,05} then {05,07}: release 04, press 07, nothing for 05.
        keycode_in = 48'h0000_0000_0504;
        settle("settle2a");
        pop_expect("pop_105", 32'h105);
        keycode_in = 48'h0000_0000_0705;
        settle("settle2b");
        check("swap_count", 32'(fifo_count), 32'd2);
        pop_expect("pop_rel_004", 32'h004);
        pop_expect("pop_prs_107", 32'h107);
        check("swap_drained", 32'(fifo_count), 32'd0);

        keycode_in = '0;
        settle("settle3a");
        pop_expect("pop_rel_005", 32'h005);
        pop_expect("pop_rel_007", 32'h007);
        check("held_clear", 32'(keys_held), 32'd0);

        // Duplicate code in two slots yields one event each way.
        keycode_in = 48'h0000_0000_1616;
        settle("settle3b");
        check("dup_count", 32'(fifo_count), 32'd1);
        pop_expect("pop_dup_116", 32'h116);
        keycode_in = '0;
        settle("settle3c");
        check("dup_rel_count", 32'(fifo_count), 32'd1);
        pop_expect("pop_dup_016", 32'h016);

        // Fill the 4-deep FIFO with six single-key additions.
        rpt = '0;
        for (int k = 0; k < 6; k++) begin
            rpt[k*KEY_W +: KEY_W] = 8'h10 + 8'(k);
            keycode_in = rpt;
            if (k < 4) settle("settle_fill");
            else repeat (20) tick();
        end
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_busy",  32'(scan_busy),  32'd1);
        check("full_head",  32'(event_data), 32'h110);

        // Pop while full with a push pending: count holds, order kept.
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        check("full_pp_count", 32'(fifo_count), 32'd4);
        check("full_pp_head",  32'(event_data), 32'h111);
        repeat (20) tick();
        check("stall_count", 32'(fifo_count), 32'd4);
        check("stall_busy",  32'(scan_busy),  32'd1);
        pop_expect("drain_111", 32'h111);
        pop_expect("drain_112", 32'h112);
        pop_expect("drain_113", 32'h113);
        pop_expect("drain_114", 32'h114);
        pop_expect("drain_115", 32'h115);
        settle("settle_drain");
        check("drain_count", 32'(fifo_count), 32'd0);

        // Flush mid-scan while 0x29 is held.
        keycode_in = 48'h0000_0000_0029;
        repeat (5) tick();
        check("pre_flush_count", 32'(fifo_count), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", 32'(fifo_count),  32'd0);
        check("flush_valid", 32'(event_valid), 32'd0);
        check("flush_busy",  32'(scan_busy),   32'd0);
        check("flush_held",  32'(keys_held),   32'd0);
        settle("settle_flush");
        check("post_flush_count", 32'(fifo_count), 32'd1);
        pop_expect("post_flush_129", 32'h129);
        check("post_flush_empty", 32'(fifo_count), 32'd0);

        // Asynchronous reset in the middle of a scan.
        keycode_in = '0;
        repeat (4) tick();
        check("pre_rst_count", 32'(fifo_count), 32'd1);
        check("pre_rst_busy",  32'(scan_busy),  32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(event_valid), 32'd0);
        check("arst_data",  32'(event_data),  32'd0);
        check("arst_count", 32'(fifo_count),  32'd0);
        check("arst_busy",  32'(scan_busy),   32'd0);
        check("arst_held",  32'(keys_held),   32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy",  32'(scan_busy),  32'd0);
        check("post_rst_count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
